alu_mc: RTL and testbench

- Parametrised, multi-cycle successor of the single-cycle execute ALU.
- Takes one operation per valid/ready handshake and returns a registered result through a valid/ready handshake.
- Single-cycle integer ops complete in 1 cycle; multiply and divide run on an iterative radix-2 datapath.
- Sits in the execute stage between the operand-select/immediate mux and writeback; the pipeline stalls on in_ready.

---
 rtl/alu_mc_if.sv | 27 ++
 rtl/alu_mc.sv | 208 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Execute-stage ALU handshake bundle: operation request, flush and registered result.
// The core (slave) accepts on in_valid && in_ready and presents results on out_valid/out_ready.
interface alu_mc_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic            out_illegal;

    modport master (
        output flush, in_valid, alu_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, alu_out, out_illegal
    );

    modport slave (
        input  flush, in_valid, alu_op, op_a, op_b, out_ready,
        output in_ready, out_valid, alu_out, out_illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle integer ops plus optional iterative radix-2 mul/div.
// Define ALU_MC_MULDIV_EN to build the multiply/divide datapath and the BUSY state.
module alu_mc #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 5
) (
    input  logic    clk,
    input  logic    rst,
    alu_mc_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic            r_live;
    logic [XLEN-1:0] r_out;
    logic            r_ill;

    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_sc_res;
    logic            w_sc_hit;

    // r_live keeps in_ready low through reset and until the first edge after release
    assign bus.in_ready    = r_live && !bus.flush &&
                             ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready));
    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.alu_out     = r_out;
    assign bus.out_illegal = r_ill;
    assign w_accept        = bus.in_valid && bus.in_ready;
    assign w_shamt         = bus.op_b[SHW-1:0];

    always_comb begin
        w_sc_res = '0;
        w_sc_hit = 1'b1;
        case (bus.alu_op)
            OP_ADD:  w_sc_res = bus.op_a + bus.op_b;
            OP_SUB:  w_sc_res = bus.op_a - bus.op_b;
            OP_AND:  w_sc_res = bus.op_a & bus.op_b;
            OP_OR:   w_sc_res = bus.op_a | bus.op_b;
            OP_XOR:  w_sc_res = bus.op_a ^ bus.op_b;
            OP_SLL:  w_sc_res = bus.op_a << w_shamt;
            OP_SRL:  w_sc_res = bus.op_a >> w_shamt;
            OP_SRA:  w_sc_res = $signed(bus.op_a) >>> w_shamt;
            OP_SLT:  w_sc_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            OP_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            default: w_sc_hit = 1'b0;
        endcase
    end

`ifdef ALU_MC_MULDIV_EN
    localparam logic [OPW-1:0] OP_MUL   = OPW'(10);
    localparam logic [OPW-1:0] OP_MULH  = OPW'(11);
    localparam logic [OPW-1:0] OP_MULHU = OPW'(12);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(13);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(14);
    localparam logic [OPW-1:0] OP_REM   = OPW'(15);
    localparam logic [OPW-1:0] OP_REMU  = OPW'(16);
    localparam logic [1:0]     S_BUSY   = 2'd1;

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [SHW-1:0]  r_cnt;
    logic            r_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_sel;

    logic            w_is_md, w_is_div, w_is_rem, w_sgn, w_sa, w_sb, w_dz, w_ovf, w_sel;
    logic [XLEN-1:0] w_ma, w_mb, w_early;
    logic [XLEN:0]   w_sum, w_rsh;
    logic            w_ge;
    logic [XLEN-1:0] w_dsub, w_hi_nx, w_lo_nx, w_q, w_r, w_md_res;
    logic [2*XLEN-1:0] w_prod;

    always_comb begin
        w_is_div = (bus.alu_op == OP_DIV) || (bus.alu_op == OP_DIVU) ||
                   (bus.alu_op == OP_REM) || (bus.alu_op == OP_REMU);
        w_is_md  = w_is_div || (bus.alu_op == OP_MUL) || (bus.alu_op == OP_MULH) ||
                   (bus.alu_op == OP_MULHU);
        w_is_rem = (bus.alu_op == OP_REM) || (bus.alu_op == OP_REMU);
        w_sgn    = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_MULH) ||
                   (bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM);
        w_sa     = w_sgn && bus.op_a[XLEN-1];
        w_sb     = w_sgn && bus.op_b[XLEN-1];
        w_ma     = w_sa ? ('0 - bus.op_a) : bus.op_a;
        w_mb     = w_sb ? ('0 - bus.op_b) : bus.op_b;
        w_dz     = w_is_div && (bus.op_b == '0);
        w_ovf    = ((bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM)) &&
                   (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
        if (w_dz) begin
            w_early = w_is_rem ? bus.op_a : '1;
        end else begin
            w_early = w_is_rem ? '0 : bus.op_a;
        end
        w_sel    = w_is_div ? w_is_rem : ((bus.alu_op == OP_MULH) || (bus.alu_op == OP_MULHU));
    end

    // One iteration per BUSY cycle; the last one also applies the sign fix-up.
    // Restoring division keeps r_hi < r_b, so the trial difference always fits XLEN bits.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rsh  = {r_hi, r_lo[XLEN-1]};
        w_ge   = (w_rsh >= {1'b0, r_b});
        w_dsub = w_rsh[XLEN-1:0] - r_b;
        if (r_div) begin
            w_hi_nx = w_ge ? w_dsub : w_rsh[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod = {w_hi_nx, w_lo_nx};
        if (r_neg_q) begin
            w_prod = '0 - w_prod;
        end
        w_q = r_neg_q ? ('0 - w_lo_nx) : w_lo_nx;
        w_r = r_neg_r ? ('0 - w_hi_nx) : w_hi_nx;
        if (r_div) begin
            w_md_res = r_sel ? w_r : w_q;
        end else begin
            w_md_res = r_sel ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_out   <= '0;
            r_ill   <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_sel   <= 1'b0;
`endif
        end else begin
            r_live <= 1'b1;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_out   <= '0;
                r_ill   <= 1'b0;
            end else if (w_accept) begin
                if (w_sc_hit) begin
                    r_out   <= w_sc_res;
                    r_ill   <= 1'b0;
                    r_state <= S_HOLD;
`ifdef ALU_MC_MULDIV_EN
                end else if (w_is_md) begin
                    if (w_dz || w_ovf) begin
                        r_out   <= w_early;
                        r_ill   <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_hi    <= '0;
                        r_lo    <= w_ma;
                        r_b     <= w_mb;
                        r_cnt   <= '0;
                        r_div   <= w_is_div;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_sel   <= w_sel;
                        r_state <= S_BUSY;
                    end
`endif
                end else begin
                    r_out   <= '0;
                    r_ill   <= 1'b1;
                    r_state <= S_HOLD;
                end
`ifdef ALU_MC_MULDIV_EN
            end else if (r_state == S_BUSY) begin
                r_hi <= w_hi_nx;
                r_lo <= w_lo_nx;
                if (r_cnt == SHW'(XLEN - 1)) begin
                    r_out   <= w_md_res;
                    r_ill   <= 1'b0;
                    r_state <= S_HOLD;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
`endif
            end else if ((r_state == S_HOLD) && bus.out_ready) begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32): directed corner cases plus randomized ops
// against an arithmetic reference model; follows ALU_MC_MULDIV_EN like the design.
module tb_alu_mc;
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;
    localparam logic [4:0] OP_MULH  = 5'd11;
    localparam logic [4:0] OP_MULHU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_REM   = 5'd15;
    localparam logic [4:0] OP_REMU  = 5'd16;
`ifdef ALU_MC_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_mc_if #(.XLEN(32), .OPW(5)) bus ();
    alu_mc #(.XLEN(32), .OPW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected result, illegal flag and latency straight from the arithmetic rules.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        bit          ovf, is_md;
        sa    = $signed(a);
        sb    = $signed(b);
        sp    = longint'(sa) * longint'(sb);
        up    = {32'd0, a} * {32'd0, b};
        ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        is_md = (op >= OP_MUL) && (op <= OP_REMU);
        r     = '0;
        ill   = 1'b0;
        lat   = 1;
        if (is_md && !MD_EN) begin
            ill = 1'b1;
            return;
        end
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLL:   r = a << b[4:0];
            OP_SRL:   r = a >> b[4:0];
            OP_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:   r = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            OP_MUL:   r = sp[31:0];
            OP_MULH:  r = sp[63:32];
            OP_MULHU: r = up[63:32];
            OP_DIV: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else r = sa / sb;
            end
            OP_DIVU:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else r = sa % sb;
            end
            OP_REMU:  r = (b == 0) ? a : a % b;
            default:  ill = 1'b1;
        endcase
        if (op == OP_MUL || op == OP_MULH || op == OP_MULHU) lat = 33;
        if (op == OP_DIV || op == OP_REM) lat = (b == 0 || ovf) ? 1 : 33;
        if (op == OP_DIVU || op == OP_REMU) lat = (b == 0) ? 1 : 33;
    endfunction

    // Issue one op from IDLE, check latency/result, optionally stall the output for hold cycles.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eill;
        int          elat, lat;
        logic        rdy_seen;
        model(op, a, b, er, eill, elat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.out_ready = (hold == 0);
        #1 check({tag, ".rdy"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        lat          = 1;
        rdy_seen     = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            rdy_seen = rdy_seen | bus.in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".busyrdy"}, rdy_seen, 0);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".res"}, bus.alu_out, er);
        check({tag, ".ill"}, bus.out_illegal, eill);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold"}, {bus.out_valid, bus.in_ready, bus.alu_out}, {2'b10, er});
        end
        if (hold > 0) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1 check({tag, ".drain"}, bus.out_valid, 0);
    endtask

    task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic [4:0] op;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;

        #1;
        check("rst.state", {bus.out_valid, bus.in_ready, bus.out_illegal}, 0);
        check("rst.out", bus.alu_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst.rdy1", bus.in_ready, 1);

        // ADD then SUB back to back: results on consecutive cycles, no bubble
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_op = OP_ADD; bus.op_a = 32'd5; bus.op_b = 32'd7;
        @(posedge clk);
        #1 check("b2b.add", {bus.out_valid, bus.alu_out}, {1'b1, 32'd12});
        @(negedge clk);
        bus.alu_op = OP_SUB; bus.op_a = 32'd0; bus.op_b = 32'd1;
        @(posedge clk);
        #1 check("b2b.sub", {bus.out_valid, bus.alu_out}, {1'b1, 32'hFFFF_FFFF});
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 check("b2b.idle", bus.out_valid, 0);

        do_op("sra",   OP_SRA,   32'h8000_0000, 32'h21, 0);
        do_op("slt",   OP_SLT,   32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu",  OP_SLTU,  32'hFFFF_FFFF, 32'd1, 0);
        do_op("undef", 5'h1F,    32'h1234_5678, 32'd9, 0);
        do_op("mul",   OP_MUL,   32'hFFFF_FFFF, 32'd3, 0);
        do_op("mulh",  OP_MULH,  32'hFFFF_FFFF, 32'd3, 0);
        do_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd3, 0);
        do_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem",   OP_REM,   32'hFFFF_FFF9, 32'd2, 0);
        do_op("divu0", OP_DIVU,  32'd7, 32'd0, 0);
        do_op("rem0",  OP_REM,   32'd7, 32'd0, 0);
        do_op("divov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("bp",    OP_ADD,   32'd100, 32'd23, 5);

        // Stalled result released in the same cycle the next op is accepted
        launch(OP_ADD, 32'd1, 32'd2);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_op = OP_XOR; bus.op_a = 32'hF0F0; bus.op_b = 32'h0FF0;
        #1 check("rel.stall", {bus.out_valid, bus.in_ready, bus.alu_out}, {2'b10, 32'd3});
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1 check("rel.rdy", bus.in_ready, 1);
        @(posedge clk);
        #1 check("rel.next", {bus.out_valid, bus.alu_out}, {1'b1, 32'hFF00});
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Flush in cycle 10 of a divide, with a colliding in_valid that must be dropped
        launch(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.alu_op = OP_ADD;
        #1 check("fl.rdy0", bus.in_ready, 0);
        @(posedge clk);
        #1 check("fl.ov", bus.out_valid, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1 check("fl.rdy1", bus.in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | bus.out_valid;
        end
        check("fl.never", seen, 0);

        // Flush while a result is held
        bus.out_ready = 1'b0;
        launch(OP_OR, 32'h10, 32'h01);
        check("flh.pre", {bus.out_valid, bus.alu_out}, {1'b1, 32'h11});
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 check("flh.ov", bus.out_valid, 0);
        bus.flush = 1'b0; bus.out_ready = 1'b1;

        // Async reset between edges during a multiply
        launch(OP_MUL, 32'd12345, 32'd678);
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("arst.now", {bus.out_valid, bus.in_ready}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("arst.rdy", bus.in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | bus.out_valid;
        end
        check("arst.never", seen, 0);

        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 19));
            if (op > 5'd16) op = 5'($urandom_range(17, 31));
            do_op("rnd", op, pick_val(), pick_val(), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
